// File: rtl/brp_gshare.sv
// Bimodal/gshare branch predictor: 2-bit counter PHT cleared by a walk FSM after reset,
// registered IF-stage prediction records, EX-stage training and accuracy counters.
module brp_gshare #(
    parameter int PHT_IDX_W = 7,
    parameter int GHR_W     = 7,
    parameter int MODE      = 1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [31:0]          pc_if,
    input  logic [6:0]           opcode_if,
    input  logic [31:0]          b_imm,
    input  logic [31:0]          j_imm,
    input  logic                 upd_valid,
    input  logic [PHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_pred,
    input  logic                 upd_taken,
    output logic                 ready,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic [31:0]          pred_alt,
    output logic [PHT_IDX_W-1:0] pred_idx,
    output logic                 mispredict,
    output logic [CNT_W-1:0]     c_total,
    output logic [CNT_W-1:0]     c_correct
);
    localparam int          ENTRIES = 1 << PHT_IDX_W;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic [PHT_IDX_W-1:0]   w_q, w_d;
    logic [GHR_W-1:0]       ghr_q, ghr_d;
    logic [1:0]             pht_q [ENTRIES];
    logic                   ready_q, ready_d;
    logic                   pv_q, pv_d, pt_q, pt_d, misp_q, misp_d;
    logic [31:0]            tgt_q, tgt_d, alt_q, alt_d;
    logic [PHT_IDX_W-1:0]   pidx_q, pidx_d;
    logic [CNT_W-1:0]       tot_q, tot_d, cor_q, cor_d;

    logic                   pht_we;
    logic [PHT_IDX_W-1:0]   pht_waddr;
    logic [1:0]             pht_wdata, cur_cnt;
    logic [PHT_IDX_W-1:0]   base, idx;
    logic [31:0]            jump_pc, seq_pc;
    logic                   hit, take;

    // Prediction record; reads the PHT and GHR before this cycle's training lands.
    always_comb begin
        base    = pc_if[PHT_IDX_W+1:2];
        idx     = (MODE == 1) ? (base ^ PHT_IDX_W'(ghr_q)) : base;
        seq_pc  = pc_if + 32'd4;
        jump_pc = '0;
        hit     = 1'b0;
        take    = 1'b0;
        pv_d    = 1'b0;
        pidx_d  = '0;
        if (state_q == S_RUN && load) begin
            if (opcode_if == OP_BR) begin
                hit     = 1'b1;
                take    = pht_q[idx][1];
                pv_d    = 1'b1;
                pidx_d  = idx;
                jump_pc = pc_if + b_imm;
            end else if (opcode_if == OP_JAL) begin
                hit     = 1'b1;
                take    = 1'b1;
                jump_pc = pc_if + j_imm;
            end
        end
        pt_d  = hit & take;
        tgt_d = !hit ? 32'd0 : (take ? jump_pc : seq_pc);
        alt_d = !hit ? 32'd0 : (take ? seq_pc : jump_pc);
    end

    // Walk FSM and training.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        ghr_d     = ghr_q;
        misp_d    = 1'b0;
        tot_d     = tot_q;
        cor_d     = cor_q;
        ready_d   = (state_q == S_RUN);
        pht_we    = 1'b0;
        pht_waddr = w_q;
        pht_wdata = 2'b01;
        cur_cnt   = pht_q[upd_idx];
        case (state_q)
            S_INIT: begin
                pht_we = 1'b1;
                w_d    = w_q + 1'b1;
                if (w_q == '1) state_d = S_RUN;
            end
            S_RUN: begin
                if (upd_valid) begin
                    pht_we    = 1'b1;
                    pht_waddr = upd_idx;
                    if (upd_taken) pht_wdata = (cur_cnt == 2'd3) ? 2'd3 : cur_cnt + 2'd1;
                    else           pht_wdata = (cur_cnt == 2'd0) ? 2'd0 : cur_cnt - 2'd1;
                    ghr_d  = GHR_W'({ghr_q, upd_taken});
                    misp_d = (upd_pred != upd_taken);
                    if (tot_q != '1) tot_d = tot_q + 1'b1;
                    if (upd_pred == upd_taken && cor_q != '1) cor_d = cor_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            w_q     <= '0;
            ghr_q   <= '0;
            ready_q <= 1'b0;
            pv_q    <= 1'b0;
            pt_q    <= 1'b0;
            tgt_q   <= '0;
            alt_q   <= '0;
            pidx_q  <= '0;
            misp_q  <= 1'b0;
            tot_q   <= '0;
            cor_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            ghr_q   <= ghr_d;
            ready_q <= ready_d;
            pv_q    <= pv_d;
            pt_q    <= pt_d;
            tgt_q   <= tgt_d;
            alt_q   <= alt_d;
            pidx_q  <= pidx_d;
            misp_q  <= misp_d;
            tot_q   <= tot_d;
            cor_q   <= cor_d;
        end
    end

    // No reset on the table itself: the INIT walk clears it.
    always_ff @(posedge clk) begin
        if (pht_we) pht_q[pht_waddr] <= pht_wdata;
    end

    assign ready       = ready_q;
    assign pred_valid  = pv_q;
    assign pred_taken  = pt_q;
    assign pred_target = tgt_q;
    assign pred_alt    = alt_q;
    assign pred_idx    = pidx_q;
    assign mispredict  = misp_q;
    assign c_total     = tot_q;
    assign c_correct   = cor_q;
endmodule

// File: tb/tb_brp_gshare.sv
// Bench for brp_gshare: a bimodal (32-bit counters) and a gshare (4-bit counters) instance
// share stimulus and are compared each cycle against an array-based predictor model.
module tb_brp_gshare;
    localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6F, OP_LUI = 7'h37, OP_JALR = 7'h67;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, upd_valid, upd_pred, upd_taken;
    logic [31:0] pc_if, b_imm, j_imm;
    logic [6:0]  opcode_if, upd_idx;
    logic        rdy [2], pv [2], pt [2], misp [2];
    logic [31:0] ptg [2], palt [2];
    logic [6:0]  pidx [2];
    logic [31:0] ctot0, ccor0;
    logic [3:0]  ctot1, ccor1;

    brp_gshare #(.PHT_IDX_W(7), .GHR_W(7), .MODE(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .load(load), .pc_if(pc_if), .opcode_if(opcode_if),
        .b_imm(b_imm), .j_imm(j_imm), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_pred(upd_pred), .upd_taken(upd_taken), .ready(rdy[0]), .pred_valid(pv[0]),
        .pred_taken(pt[0]), .pred_target(ptg[0]), .pred_alt(palt[0]), .pred_idx(pidx[0]),
        .mispredict(misp[0]), .c_total(ctot0), .c_correct(ccor0));

    brp_gshare #(.PHT_IDX_W(7), .GHR_W(7), .MODE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .load(load), .pc_if(pc_if), .opcode_if(opcode_if),
        .b_imm(b_imm), .j_imm(j_imm), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_pred(upd_pred), .upd_taken(upd_taken), .ready(rdy[1]), .pred_valid(pv[1]),
        .pred_taken(pt[1]), .pred_target(ptg[1]), .pred_alt(palt[1]), .pred_idx(pidx[1]),
        .mispredict(misp[1]), .c_total(ctot1), .c_correct(ccor1));

    int n_assert = 0, n_fail = 0;

    // Reference model state.
    int          pht [2][128];
    int          ghr [2];
    longint      tot [2], cor [2];
    longint      cmax [2] = '{64'hFFFFFFFF, 64'd15};
    logic        e_pv [2], e_pt [2], e_misp [2];
    logic [31:0] e_tg [2], e_alt [2];
    logic [6:0]  e_idx [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 128; i++) pht[d][i] = 1;
            ghr[d] = 0; tot[d] = 0; cor[d] = 0;
            e_pv[d] = 0; e_pt[d] = 0; e_misp[d] = 0; e_tg[d] = 0; e_alt[d] = 0; e_idx[d] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] ot, oc;
        for (int d = 0; d < 2; d++) begin
            ot = (d == 0) ? 64'(ctot0) : 64'(ctot1);
            oc = (d == 0) ? 64'(ccor0) : 64'(ccor1);
            chk($sformatf("%s d%0d ready", tag, d), rdy[d], 1'b1);
            chk($sformatf("%s d%0d pred_valid", tag, d), pv[d], e_pv[d]);
            chk($sformatf("%s d%0d pred_taken", tag, d), pt[d], e_pt[d]);
            chk($sformatf("%s d%0d pred_target", tag, d), ptg[d], e_tg[d]);
            chk($sformatf("%s d%0d pred_alt", tag, d), palt[d], e_alt[d]);
            chk($sformatf("%s d%0d pred_idx", tag, d), pidx[d], e_idx[d]);
            chk($sformatf("%s d%0d mispredict", tag, d), misp[d], e_misp[d]);
            chk($sformatf("%s d%0d c_total", tag, d), ot, tot[d]);
            chk($sformatf("%s d%0d c_correct", tag, d), oc, cor[d]);
        end
    endtask

    // One clock in RUN: predict from the pre-update model, then train, then compare.
    task automatic tick(input string tag);
        for (int d = 0; d < 2; d++) begin
            logic [31:0] off, jmp;
            logic        taken;
            int          ix;
            e_pv[d] = 0; e_pt[d] = 0; e_tg[d] = 0; e_alt[d] = 0; e_idx[d] = 0;
            if (load && (opcode_if == OP_BR || opcode_if == OP_JAL)) begin
                if (opcode_if == OP_BR) begin
                    ix = int'((pc_if >> 2) % 128);
                    if (d == 1) ix = ix ^ ghr[d];
                    taken = (pht[d][ix] >= 2);
                    e_pv[d] = 1; e_idx[d] = 7'(ix); off = b_imm;
                end else begin
                    taken = 1; off = j_imm;
                end
                jmp = pc_if + off;
                e_pt[d]  = taken;
                e_tg[d]  = taken ? jmp : pc_if + 32'd4;
                e_alt[d] = taken ? pc_if + 32'd4 : jmp;
            end
            if (upd_valid) begin
                if (upd_taken) pht[d][upd_idx] = (pht[d][upd_idx] == 3) ? 3 : pht[d][upd_idx] + 1;
                else           pht[d][upd_idx] = (pht[d][upd_idx] == 0) ? 0 : pht[d][upd_idx] - 1;
                ghr[d] = (ghr[d] * 2 + int'(upd_taken)) % 128;
                if (tot[d] < cmax[d]) tot[d]++;
                if (upd_pred == upd_taken && cor[d] < cmax[d]) cor[d]++;
                e_misp[d] = (upd_pred != upd_taken);
            end else begin
                e_misp[d] = 0;
            end
        end
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic wait_ready(input string tag);
        int first;
        first = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (rdy[0] === 1'b1) begin first = i; break; end
        end
        chk({tag, " ready edge"}, first, 129);
        chk({tag, " ready gshare"}, rdy[1], 1'b1);
    endtask

    task automatic idle_inputs();
        load = 0; pc_if = 0; opcode_if = 0; b_imm = 0; j_imm = 0;
        upd_valid = 0; upd_idx = 0; upd_pred = 0; upd_taken = 0;
    endtask

    task automatic set_br(input logic [31:0] pc, input logic [31:0] imm);
        load = 1; opcode_if = OP_BR; pc_if = pc; b_imm = imm;
    endtask

    task automatic set_upd(input logic v, input logic [6:0] ix, input logic p, input logic t);
        upd_valid = v; upd_idx = ix; upd_pred = p; upd_taken = t;
    endtask

    initial begin
        logic tk [10];
        logic pr [10];
        int   pulses;
        idle_inputs();
        model_reset();

        // Reset state
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst d%0d ready", d), rdy[d], 1'b0);
            chk($sformatf("rst d%0d pred", d), {pv[d], pt[d], ptg[d], palt[d], pidx[d]}, 64'd0);
            chk($sformatf("rst d%0d misp", d), misp[d], 1'b0);
        end
        chk("rst c_total", ctot0, 0);
        chk("rst c_correct", ccor1, 0);
        rst = 0;
        wait_ready("init");

        // Fresh table predicts weakly not-taken
        set_br(32'h100, 32'h20);
        tick("br_fresh");
        chk("br_fresh taken", pt[0], 1'b0);
        chk("br_fresh target", ptg[0], 32'h104);
        chk("br_fresh alt", palt[0], 32'h120);
        chk("br_fresh idx", pidx[0], 7'h40);
        load = 0;
        for (int i = 0; i < 3; i++) begin set_upd(1, 7'h40, 0, 1); tick("train_t"); end
        set_br(32'h100, 32'h20);
        tick("br_sat_4th_upd");
        chk("br_sat taken", pt[0], 1'b1);
        chk("br_sat target", ptg[0], 32'h120);
        set_upd(1, 7'h40, 1, 0); load = 0;
        tick("one_nt");
        set_upd(0, 0, 0, 0); set_br(32'h100, 32'h20);
        tick("after_sat_nt");
        chk("after_sat_nt taken", pt[0], 1'b1);

        // JAL, non-branch, and load low
        load = 1; opcode_if = OP_JAL; pc_if = 32'h200; j_imm = 32'hFFFFFFF0;
        tick("jal");
        chk("jal record", {pv[0], pt[0], pidx[0]}, {1'b0, 1'b1, 7'h0});
        chk("jal target", ptg[0], 32'h1F0);
        chk("jal alt", palt[0], 32'h204);
        opcode_if = OP_LUI;
        tick("lui");
        chk("lui zero", {pv[0], pt[0], ptg[0]}, 33'd0);
        set_br(32'h100, 32'h20); load = 0;
        tick("load_low");
        idle_inputs();

        // Reset in RUN, then reset again mid-walk at w = 50
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rerst ready", rdy[0], 1'b0);
        chk("rerst c_total", ctot0, 0);
        rst = 0;
        repeat (50) @(posedge clk);
        #1;
        chk("walk50 ready", rdy[0], 1'b0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        wait_ready("rewalk");

        // Ten updates, seven correct; last seven outcomes leave GHR = 0000101
        tk = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1};
        pr = '{1, 0, 1, 0, 1, 0, 0, 1, 1, 1};
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            set_upd(1, 7'h10, pr[i], tk[i]);
            tick("cnt_upd");
            if (misp[0] === 1'b1) pulses++;
        end
        set_upd(0, 0, 0, 0);
        set_br(32'h100, 32'h20);
        tick("ghr_br");
        if (misp[0] === 1'b1) pulses++;
        chk("misp pulses", pulses, 3);
        chk("c_total 10", ctot0, 10);
        chk("c_correct 7", ccor0, 7);
        chk("c_total 10 narrow", ctot1, 10);
        chk("c_correct 7 narrow", ccor1, 7);
        chk("gshare idx", pidx[1], 7'h45);
        chk("bimodal idx", pidx[0], 7'h40);

        // Random traffic, including same-index read/update and narrow counter saturation
        for (int n = 0; n < 400; n++) begin
            int sel;
            load = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 3);
            opcode_if = (sel == 0) ? OP_JAL : (sel == 1) ? OP_LUI : (sel == 2) ? OP_JALR : OP_BR;
            if ($urandom_range(0, 1) == 1) opcode_if = OP_BR;
            pc_if = 32'h100 + ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) pc_if = $urandom;
            b_imm = $urandom; j_imm = $urandom;
            set_upd(($urandom_range(0, 2) != 0), 7'(7'h40 + $urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
